// File: rtl/sseg_scan_if.sv
// ----------------------------------------------------------------------------
// sseg_scan_if
// Bundle of the display-side signals of sseg_scan_ctrl.
//   run        : 1 = scan the digits, 0 = display dark
//   load       : one-cycle strobe capturing hex_in/dp_in
//   hex_in     : four hex nibbles, nibble k = digit k (digit 3 most significant)
//   dp_in      : decimal point per digit, 1 = lit
//   digit_en   : live per-digit enable, 0 = digit kept dark
//   sseg       : active-low segments, bit 0..6 = a..g, bit 7 = dp
//   en_dig     : active-low digit select, at most one bit low
//   frame_done : one-cycle pulse after digit 3's slot
// master drives the controls (upstream logic / bench), slave is the controller.
// ----------------------------------------------------------------------------
interface sseg_scan_if;
    logic        run;
    logic        load;
    logic [15:0] hex_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_en;
    logic [7:0]  sseg;
    logic [3:0]  en_dig;
    logic        frame_done;

    modport master (
        output run, load, hex_in, dp_in, digit_en,
        input  sseg, en_dig, frame_done
    );

    modport slave (
        input  run, load, hex_in, dp_in, digit_en,
        output sseg, en_dig, frame_done
    );
endinterface

// File: rtl/sseg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// sseg_scan_ctrl
// Time-multiplexes one 8-bit seven-segment bus across four common-anode
// digits. Digits 0..3 are scanned round-robin, each slot is SLOT_CYC cycles
// long and starts with BLANK_CYC all-dark cycles to suppress ghosting.
// Displayed data comes from a shadow register that only changes at frame
// boundaries (or while the display is off), so a frame never mixes old and
// new values.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : sseg_scan_if.slave (run, load, hex_in, dp_in, digit_en in;
//           sseg, en_dig, frame_done out, all registered)
//
// Parameters:
//   SLOT_CYC  : cycles per digit slot, blank included (> BLANK_CYC)
//   BLANK_CYC : dark cycles at the start of each slot (>= 1)
//   CNT_W     : slot counter width (2**CNT_W >= SLOT_CYC)
//
// Build option:
//   SSEG_LZB_EN : when defined, leading zeros (digits 3..1) are blanked.
// ----------------------------------------------------------------------------
module sseg_scan_ctrl #(
    parameter int SLOT_CYC  = 50000,
    parameter int BLANK_CYC = 8,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    sseg_scan_if.slave  bus
);

    localparam logic [1:0] S_OFF   = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_SHOW  = 2'd2;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYC - 1);

    logic [1:0]       state, nxt_state;
    logic [1:0]       idx, nxt_idx;
    logic [CNT_W-1:0] cnt, nxt_cnt;
    logic             boundary;

    logic [15:0]      shadow_hex, pend_hex;
    logic [3:0]       shadow_dp, pend_dp;
    logic             pend;

    logic [3:0]       dark_lz;
    logic [3:0]       nxt_en;
    logic [7:0]       nxt_sseg;

    // Active-low segment pattern; a lit decimal point clears bit 7.
    function automatic logic [7:0] seg_decode(input logic [3:0] nib, input logic dp);
        logic [7:0] pat;
        case (nib)
            4'h0: pat = 8'hC0;
            4'h1: pat = 8'hF9;
            4'h2: pat = 8'hA4;
            4'h3: pat = 8'hB0;
            4'h4: pat = 8'h99;
            4'h5: pat = 8'h92;
            4'h6: pat = 8'h82;
            4'h7: pat = 8'hF8;
            4'h8: pat = 8'h80;
            4'h9: pat = 8'h90;
            4'hA: pat = 8'h88;
            4'hB: pat = 8'h83;
            4'hC: pat = 8'hC6;
            4'hD: pat = 8'hA1;
            4'hE: pat = 8'h86;
            default: pat = 8'h8E;
        endcase
        return dp ? (pat & 8'h7F) : pat;
    endfunction

`ifdef SSEG_LZB_EN
    // Digit k is a leading zero when it and every higher nibble are zero and
    // its own dp is off. Derived from the shadow, so stable for a whole frame.
    always_comb begin
        dark_lz    = 4'b0000;
        dark_lz[3] = (shadow_hex[15:12] == 4'h0)  && !shadow_dp[3];
        dark_lz[2] = (shadow_hex[15:8]  == 8'h00) && !shadow_dp[2];
        dark_lz[1] = (shadow_hex[15:4]  == 12'h0) && !shadow_dp[1];
    end
`else
    assign dark_lz = 4'b0000;
`endif

    // Scan sequencing; run=0 overrides everything and parks in OFF.
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt;
        boundary  = 1'b0;
        if (!bus.run) begin
            nxt_state = S_OFF;
            nxt_idx   = 2'd0;
            nxt_cnt   = '0;
        end else begin
            case (state)
                S_OFF: begin
                    nxt_state = S_BLANK;
                    nxt_idx   = 2'd0;
                    nxt_cnt   = '0;
                end
                S_BLANK: begin
                    nxt_cnt = cnt + 1'b1;
                    if (cnt == BLANK_LAST)
                        nxt_state = S_SHOW;
                end
                S_SHOW: begin
                    if (cnt == SLOT_LAST) begin
                        nxt_state = S_BLANK;
                        nxt_cnt   = '0;
                        nxt_idx   = idx + 2'd1;
                        boundary  = (idx == 2'd3);
                    end else begin
                        nxt_cnt = cnt + 1'b1;
                    end
                end
                default: begin
                    nxt_state = S_OFF;
                    nxt_idx   = 2'd0;
                    nxt_cnt   = '0;
                end
            endcase
        end
    end

    // Outputs are computed from the next state so they register on the same
    // edge as the transition. The shadow only changes on edges that lead to
    // BLANK or OFF, so its current value is the one shown in the next SHOW.
    always_comb begin
        nxt_en   = 4'hF;
        nxt_sseg = 8'hFF;
        if (nxt_state == S_SHOW && bus.digit_en[nxt_idx] && !dark_lz[nxt_idx]) begin
            nxt_en[nxt_idx] = 1'b0;
            nxt_sseg        = seg_decode(shadow_hex[{nxt_idx, 2'b00} +: 4], shadow_dp[nxt_idx]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_OFF;
            idx            <= 2'd0;
            cnt            <= '0;
            bus.en_dig     <= 4'hF;
            bus.sseg       <= 8'hFF;
            bus.frame_done <= 1'b0;
        end else begin
            state          <= nxt_state;
            idx            <= nxt_idx;
            cnt            <= nxt_cnt;
            bus.en_dig     <= nxt_en;
            bus.sseg       <= nxt_sseg;
            bus.frame_done <= boundary;
        end
    end

    // Shadow / pending update. A load that lands on the frame boundary is the
    // newest data, so it goes straight to the shadow and discards any pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_hex <= 16'h0000;
            shadow_dp  <= 4'h0;
            pend       <= 1'b0;
        end else if (state == S_OFF) begin
            if (bus.load) begin
                shadow_hex <= bus.hex_in;
                shadow_dp  <= bus.dp_in;
                pend       <= 1'b0;
            end
        end else if (boundary) begin
            if (bus.load) begin
                shadow_hex <= bus.hex_in;
                shadow_dp  <= bus.dp_in;
            end else if (pend) begin
                shadow_hex <= pend_hex;
                shadow_dp  <= pend_dp;
            end
            pend <= 1'b0;
        end else if (bus.load) begin
            pend <= 1'b1;
        end
    end

    // Pending data is qualified by pend, so it needs no reset.
    always_ff @(posedge clk) begin
        if (bus.load) begin
            pend_hex <= bus.hex_in;
            pend_dp  <= bus.dp_in;
        end
    end

endmodule
